// File: rtl/mult_fu.sv
// Iterative signed/unsigned multiplier unit: STAGES partial-product cycles per op, result held until written.
// Optional MULT_FU_SQUASH_EN adds a squash input that drops any in-flight or finished op.
module mult_fu #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 4,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [XLEN-1:0]       opa,
  input  logic [XLEN-1:0]       opb,
  input  logic [1:0]            func,
  input  logic [TAG_W-1:0]      dest_tag,
  // {valid, value[XLEN-1:0], tag[TAG_W-1:0]}
  output logic [XLEN+TAG_W:0]   ex_packet_out,
  input  logic                  written,
`ifdef MULT_FU_SQUASH_EN
  input  logic                  squash,
`endif
  output logic                  busy
);

  localparam int unsigned W  = XLEN / STAGES;
  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned CW = $clog2(STAGES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    a_sh, acc, slice_ext;
  logic [XLEN-1:0]  b_sh, value;
  logic             b_signed, slice_sign, last_step;
  logic [1:0]       func_q;
  logic [TAG_W-1:0] tag_q;
  logic [CW-1:0]    cnt;
  logic             accept, squash_now, a_sgn, valid;

`ifdef MULT_FU_SQUASH_EN
  assign squash_now = squash;
`else
  assign squash_now = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    issue_ready = !squash_now && (state_q == IDLE || (state_q == DONE && written));
    accept      = issue_valid && issue_ready;
    case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: if (last_step) state_d = DONE;
      DONE: if (written) state_d = accept ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
    if (squash_now) state_d = IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Multiplier slice is consumed LSB first; the top slice carries negative weight for signed opb.
  assign last_step  = (cnt == CW'(STAGES - 1));
  assign slice_sign = last_step && b_signed && b_sh[W-1];
  assign slice_ext  = {{(PW-W){slice_sign}}, b_sh[W-1:0]};
  assign a_sgn      = (func != 2'b11) && opa[XLEN-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_sh     <= '0;
      b_sh     <= '0;
      b_signed <= 1'b0;
      func_q   <= '0;
      tag_q    <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else if (accept) begin
      a_sh     <= {{XLEN{a_sgn}}, opa};
      b_sh     <= opb;
      b_signed <= !func[1];
      func_q   <= func;
      tag_q    <= dest_tag;
      acc      <= '0;
      cnt      <= '0;
    end else if (state_q == BUSY && !squash_now) begin
      acc      <= acc + a_sh * slice_ext;
      a_sh     <= a_sh << W;
      b_sh     <= b_sh >> W;
      cnt      <= cnt + 1'b1;
    end
  end

  assign valid = (state_q == DONE);
  assign value = (func_q == 2'b00) ? acc[XLEN-1:0] : acc[PW-1:XLEN];
  assign busy  = (state_q != IDLE);

  assign ex_packet_out = {valid, valid ? value : '0, valid ? tag_q : '0};

endmodule

// File: doc/mult_fu.md
MULT_FU -- requirements
Module: mult_fu

Interface
REQ-001 Parameter: STAGES, default 4, iterative multiply cycles per operation; XLEN SHALL be divisible by STAGES.
REQ-002 Parameter: TAG_W, default 5, width of the destination tag.
REQ-003 Port: clock  input  1  single clock, all state on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: issue_valid  input  1  operation offered this cycle.
REQ-006 Port: issue_ready  output  1  unit accepts offered operation this cycle.
REQ-007 Port: opa, opb  input  XLEN each  multiplicand, multiplier.
REQ-008 Port: func  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-009 Port: dest_tag  input  TAG_W  tag returned with result.
REQ-010 Port: ex_packet_out  output  CDB_DATA  valid/value/tag result offered to the write-result stage.
REQ-011 Port: written  input  1  this unit's bit of the write-result stage's written vector; result consumed this cycle.
REQ-012 Port: busy  output  1  state is BUSY or DONE.

Function
REQ-013 FSM states SHALL be IDLE, BUSY, DONE.
REQ-014 issue_ready SHALL be 1 in IDLE, and 1 in DONE when written=1; 0 otherwise (combinational).
REQ-015 Accept = issue_valid & issue_ready; on accept, latch operands, func, dest_tag, clear accumulator, counter=0, go BUSY.
REQ-016 BUSY: each cycle add the partial product of the sign/zero-extended 2*XLEN multiplicand and the next XLEN/STAGES multiplier bits (LSB first) into a 2*XLEN accumulator; counter increments.
REQ-017 Operand extension: MUL/MULH both signed; MULHSU opa signed, opb unsigned; MULHU both unsigned; top multiplier slice SHALL be weighted negatively when opb is signed.
REQ-018 After STAGES BUSY cycles, go DONE; ex_packet_out.valid SHALL assert exactly STAGES cycles after the accept edge.
REQ-019 value: MUL = product[XLEN-1:0]; others = product[2*XLEN-1:XLEN]; tag = latched dest_tag.
REQ-020 DONE: valid, value, tag SHALL hold stable until written=1.
REQ-021 DONE with written=1: go BUSY if a new op is accepted the same cycle, else IDLE; no bubble cycle required.
REQ-022 written while not DONE SHALL be ignored.
REQ-023 issue_valid while issue_ready=0 SHALL be ignored; upstream holds the op.
REQ-024 ex_packet_out.valid SHALL be 0 in IDLE and BUSY; value/tag are don't-care when valid=0.

Reset
REQ-025 reset=0 SHALL immediately force IDLE, ex_packet_out.valid=0, value=0, tag=0, busy=0, counter=0, accumulator=0, regardless of clock.
REQ-026 Reset mid-operation SHALL discard the in-flight op; no result is produced after release.
REQ-027 First accept possible on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro MULT_FU_SQUASH_EN: when defined, adds input squash (1 bit); squash=1 on an edge forces IDLE and drops any BUSY/DONE result, and takes priority over accept and written that cycle.
REQ-029 Without MULT_FU_SQUASH_EN, no squash port exists; ops always run to completion.

Verification
REQ-030 Reset: assert reset=0 mid-BUSY -> valid=0, busy=0 immediately, no result after release.
REQ-031 MUL 7*6, tag 3, STAGES=4 -> valid rises 4 cycles after accept, value=42, tag=3, issue_ready=0 until written.
REQ-032 MULH 0x80000000*0x80000000 (XLEN=32) -> value=0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
REQ-033 Hold written=0 for 5 cycles in DONE -> valid, value, tag stable; pulse written=1 -> valid=0 next cycle.
REQ-034 Back-to-back: written=1 and new issue_valid in the same DONE cycle -> accepted, next result valid 4 cycles later, no lost op.
REQ-035 With MULT_FU_SQUASH_EN: squash during BUSY and during DONE -> IDLE next cycle, valid=0, no result emitted.
